// File: rtl/ahb_slave_if_param_if.sv
// ahb_slave_if_param_if
// AHB-Lite bus signals between an AHB master/interconnect and the bridge slave
// front-end.
//   master modport: drives hwrite, hreadyin, htrans, haddr, hwdata;
//                   receives hrdata, hresp, hreadyout
//   slave modport : the reverse direction of every signal
interface ahb_slave_if_param_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              hwrite;
  logic              hreadyin;
  logic [1:0]        htrans;
  logic [ADDR_W-1:0] haddr;
  logic [DATA_W-1:0] hwdata;
  logic [DATA_W-1:0] hrdata;
  logic              hresp;
  logic              hreadyout;

  modport master (
    output hwrite, hreadyin, htrans, haddr, hwdata,
    input  hrdata, hresp, hreadyout
  );

  modport slave (
    input  hwrite, hreadyin, htrans, haddr, hwdata,
    output hrdata, hresp, hreadyout
  );
endinterface

// File: rtl/ahb_slave_if_param.sv
// ahb_slave_if_param
// AHB-Lite slave front-end of the AHB-to-APB bridge. Decodes transfers into
// NUM_SEL equal-sized APB regions, pipelines address/data/write PIPE_DEPTH
// stages deep (advancing only on hreadyin) and answers out-of-range
// NONSEQ/SEQ transfers with a two-cycle AHB ERROR response.
// Ports:
//   hclk, hreset : clock, synchronous active-high reset
//   bus          : AHB slave modport (hwrite, hreadyin, htrans, haddr, hwdata
//                  in; hrdata, hresp, hreadyout out)
//   prdata       : APB read data, forwarded unregistered as hrdata
//   haddr_p, hwdata_p, hwrite_p : pipelines, stage 0 newest, stage k at
//                  [k*W +: W]
//   valid        : in-range transfer accepted this cycle (combinational)
//   temp_selx    : one-hot region decode of haddr (combinational)
//   selx_q       : temp_selx captured on valid cycles
// Optional build macro AHB_SLV_STATS_EN adds saturating 16-bit counters
// xfer_cnt (valid cycles) and err_cnt (error sequences started).
module ahb_slave_if_param #(
  parameter int          ADDR_W      = 32,
  parameter int          DATA_W      = 32,
  parameter int          NUM_SEL     = 3,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter logic [31:0] REGION_SIZE = 32'h0400_0000,
  parameter int          PIPE_DEPTH  = 2
) (
  input  logic                         hclk,
  input  logic                         hreset,
  ahb_slave_if_param_if.slave          bus,
  input  logic [DATA_W-1:0]            prdata,
  output logic [ADDR_W*PIPE_DEPTH-1:0] haddr_p,
  output logic [DATA_W*PIPE_DEPTH-1:0] hwdata_p,
  output logic [PIPE_DEPTH-1:0]        hwrite_p,
`ifdef AHB_SLV_STATS_EN
  output logic [15:0]                  xfer_cnt,
  output logic [15:0]                  err_cnt,
`endif
  output logic                         valid,
  output logic [NUM_SEL-1:0]           temp_selx,
  output logic [NUM_SEL-1:0]           selx_q
);

  // Four spare bits keep BASE + NUM_SEL*REGION_SIZE from wrapping.
  localparam int EXT_W = ADDR_W + 4;
  localparam logic [EXT_W-1:0] BASE_EXT = EXT_W'(BASE_ADDR);
  localparam logic [EXT_W-1:0] SIZE_EXT = EXT_W'(REGION_SIZE);
  localparam logic [EXT_W-1:0] TOP_EXT  = BASE_EXT + EXT_W'(NUM_SEL) * SIZE_EXT;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t           state;
  logic [EXT_W-1:0] addr_ext;
  logic             in_range;
  logic             active;
  logic             err_start;

  assign addr_ext  = EXT_W'(bus.haddr);
  assign in_range  = (addr_ext >= BASE_EXT) && (addr_ext < TOP_EXT);
  assign active    = bus.hreadyin && bus.htrans[1];
  assign valid     = active && in_range && (state == ST_IDLE);
  assign err_start = active && !in_range && (state == ST_IDLE);
  assign bus.hrdata = prdata;

  // Region decode: each bit tests its own half-open window, so at most one is set.
  always_comb begin
    temp_selx = {NUM_SEL{1'b0}};
    for (int i = 0; i < NUM_SEL; i++) begin
      if ((addr_ext >= BASE_EXT + EXT_W'(i) * SIZE_EXT) &&
          (addr_ext <  BASE_EXT + EXT_W'(i + 1) * SIZE_EXT)) begin
        temp_selx[i] = 1'b1;
      end else begin
        temp_selx[i] = 1'b0;
      end
    end
  end

  // Address/data/write pipelines, shifted only while the bus is ready.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      haddr_p  <= {(ADDR_W*PIPE_DEPTH){1'b0}};
      hwdata_p <= {(DATA_W*PIPE_DEPTH){1'b0}};
      hwrite_p <= {PIPE_DEPTH{1'b0}};
    end else if (bus.hreadyin) begin
      haddr_p[ADDR_W-1:0]  <= bus.haddr;
      hwdata_p[DATA_W-1:0] <= bus.hwdata;
      hwrite_p[0]          <= bus.hwrite;
      for (int k = 1; k < PIPE_DEPTH; k++) begin
        haddr_p[k*ADDR_W +: ADDR_W]  <= haddr_p[(k-1)*ADDR_W +: ADDR_W];
        hwdata_p[k*DATA_W +: DATA_W] <= hwdata_p[(k-1)*DATA_W +: DATA_W];
        hwrite_p[k]                  <= hwrite_p[k-1];
      end
    end
  end

  // Region select capture for accepted transfers.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      selx_q <= {NUM_SEL{1'b0}};
    end else if (valid) begin
      selx_q <= temp_selx;
    end
  end

  // Error-response FSM; hresp/hreadyout are loaded with the next state's values.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      state         <= ST_IDLE;
      bus.hresp     <= 1'b0;
      bus.hreadyout <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (err_start) begin
            state         <= ST_ERR1;
            bus.hresp     <= 1'b1;
            bus.hreadyout <= 1'b0;
          end else begin
            bus.hresp     <= 1'b0;
            bus.hreadyout <= 1'b1;
          end
        end
        // A master cancel during the first error cycle cannot cut it short.
        ST_ERR1: begin
          state         <= ST_ERR2;
          bus.hresp     <= 1'b1;
          bus.hreadyout <= 1'b1;
        end
        ST_ERR2: begin
          state         <= ST_IDLE;
          bus.hresp     <= 1'b0;
          bus.hreadyout <= 1'b1;
        end
        default: begin
          state         <= ST_IDLE;
          bus.hresp     <= 1'b0;
          bus.hreadyout <= 1'b1;
        end
      endcase
    end
  end

`ifdef AHB_SLV_STATS_EN
  // Saturating transfer and error-sequence counters.
  always_ff @(posedge hclk) begin
    if (hreset) begin
      xfer_cnt <= 16'd0;
      err_cnt  <= 16'd0;
    end else begin
      if (valid && (xfer_cnt != 16'hFFFF)) begin
        xfer_cnt <= xfer_cnt + 16'd1;
      end
      if (err_start && (err_cnt != 16'hFFFF)) begin
        err_cnt <= err_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ahb_slave_if_param.sv
// tb_ahb_slave_if_param
// Randomized and directed stimulus for ahb_slave_if_param against a
// behavioural model (input history queue, error countdown, arithmetic region
// decode). Build with AHB_SLV_STATS_EN to also exercise the counters.
module tb_ahb_slave_if_param;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int NUM_SEL    = 3;
  localparam int PIPE_DEPTH = 2;
  localparam longint unsigned BASE = 64'h8000_0000;
  localparam longint unsigned RS   = 64'h0400_0000;
  localparam longint unsigned TOP  = BASE + NUM_SEL * RS;

  logic                         hclk = 1'b0;
  logic                         hreset;
  logic [DATA_W-1:0]            prdata;
  logic [ADDR_W*PIPE_DEPTH-1:0] haddr_p;
  logic [DATA_W*PIPE_DEPTH-1:0] hwdata_p;
  logic [PIPE_DEPTH-1:0]        hwrite_p;
  logic                         valid;
  logic [NUM_SEL-1:0]           temp_selx;
  logic [NUM_SEL-1:0]           selx_q;
`ifdef AHB_SLV_STATS_EN
  logic [15:0]                  xfer_cnt;
  logic [15:0]                  err_cnt;
`endif

  ahb_slave_if_param_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ahb_slave_if_param #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL),
    .BASE_ADDR(32'h8000_0000), .REGION_SIZE(32'h0400_0000),
    .PIPE_DEPTH(PIPE_DEPTH)
  ) dut (
    .hclk(hclk), .hreset(hreset), .bus(bus), .prdata(prdata),
    .haddr_p(haddr_p), .hwdata_p(hwdata_p), .hwrite_p(hwrite_p),
`ifdef AHB_SLV_STATS_EN
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt),
`endif
    .valid(valid), .temp_selx(temp_selx), .selx_q(selx_q)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [ADDR_W-1:0] a;
    logic [DATA_W-1:0] d;
    logic              w;
  } beat_t;

  // Model state
  beat_t              hist[$];   // inputs captured on enabled edges, newest first
  int                 m_err;     // error cycles still to be answered (0 = idle)
  logic [NUM_SEL-1:0] m_sel;
  int                 m_xfer;
  int                 m_errc;

  int                 compared   = 0;
  int                 mismatched = 0;
  logic               obs_valid;
  logic [NUM_SEL-1:0] obs_sel;

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 5))
      0: return 32'h8000_0000 + $urandom_range(0, 32'h0BFF_FFFF);
      1: return 32'h7FFF_FFFC;
      2: return 32'h8000_0000;
      3: return 32'h8BFF_FFFC;
      4: return 32'h8C00_0000;
      default: return $urandom;
    endcase
  endfunction

  // One bus cycle: drive at negedge, check combinational outputs, then the
  // registered ones just after the rising edge.
  task automatic step(input logic rst, input logic rdy, input logic [1:0] tr,
                      input logic [31:0] a, input logic w);
    logic [31:0]                  d;
    longint unsigned              av;
    logic                         e_act, e_inr, e_valid;
    logic [NUM_SEL-1:0]           e_sel;
    logic [ADDR_W*PIPE_DEPTH-1:0] ea;
    logic [DATA_W*PIPE_DEPTH-1:0] ed;
    logic [PIPE_DEPTH-1:0]        ew;
    beat_t                        b;
    d = $urandom;
    @(negedge hclk);
    hreset       = rst;
    bus.hreadyin = rdy;
    bus.htrans   = tr;
    bus.haddr    = a;
    bus.hwdata   = d;
    bus.hwrite   = w;
    prdata       = $urandom;
    #1;
    av      = {32'd0, a};
    e_act   = rdy && tr[1];
    e_inr   = (av >= BASE) && (av < TOP);
    e_sel   = '0;
    if (e_inr) e_sel[int'((av - BASE) / RS)] = 1'b1;
    e_valid = e_act && e_inr && (m_err == 0);
    obs_valid = valid;
    obs_sel   = temp_selx;
    chk("valid", valid, e_valid);
    chk("temp_selx", temp_selx, e_sel);
    chk("hrdata", bus.hrdata, prdata);
    @(posedge hclk);
    #1;
    if (rst) begin
      hist.delete();
      m_err = 0; m_sel = '0; m_xfer = 0; m_errc = 0;
    end else begin
      if (rdy) begin
        b.a = a; b.d = d; b.w = w;
        hist.push_front(b);
        if (hist.size() > PIPE_DEPTH) void'(hist.pop_back());
      end
      if (e_valid) begin
        m_sel = e_sel;
        if (m_xfer < 65535) m_xfer++;
      end
      if (m_err == 0) begin
        if (e_act && !e_inr) begin
          m_err = 2;
          if (m_errc < 65535) m_errc++;
        end
      end else begin
        m_err--;
      end
    end
    for (int k = 0; k < PIPE_DEPTH; k++) begin
      ea[k*ADDR_W +: ADDR_W] = (k < hist.size()) ? hist[k].a : '0;
      ed[k*DATA_W +: DATA_W] = (k < hist.size()) ? hist[k].d : '0;
      ew[k]                  = (k < hist.size()) ? hist[k].w : 1'b0;
    end
    chk("haddr_p", haddr_p, ea);
    chk("hwdata_p", hwdata_p, ed);
    chk("hwrite_p", hwrite_p, ew);
    chk("selx_q", selx_q, m_sel);
    chk("hresp", bus.hresp, m_err != 0);
    chk("hreadyout", bus.hreadyout, m_err != 2);
`ifdef AHB_SLV_STATS_EN
    chk("xfer_cnt", xfer_cnt, m_xfer[15:0]);
    chk("err_cnt", err_cnt, m_errc[15:0]);
`endif
  endtask

  initial begin
    hreset       = 1'b1;
    bus.hreadyin = 1'b1;
    bus.htrans   = 2'b00;
    bus.haddr    = 32'h0;
    bus.hwdata   = 32'h0;
    bus.hwrite   = 1'b0;
    prdata       = 32'h0;
    m_err = 0; m_sel = '0; m_xfer = 0; m_errc = 0;
    repeat (2) @(posedge hclk);
    #1;
    chk("rst_haddr_p", haddr_p, 64'h0);
    chk("rst_hwdata_p", hwdata_p, 64'h0);
    chk("rst_hwrite_p", hwrite_p, 2'b00);
    chk("rst_selx_q", selx_q, 3'b000);
    chk("rst_hresp", bus.hresp, 1'b0);
    chk("rst_hreadyout", bus.hreadyout, 1'b1);

    // Region decode
    step(1'b0, 1'b1, 2'b10, 32'h8000_0010, 1'b0);
    chk("dec_r0_sel", obs_sel, 3'b001);
    chk("dec_r0_valid", obs_valid, 1'b1);
    step(1'b0, 1'b1, 2'b10, 32'h8400_0000, 1'b0);
    chk("dec_r1_sel", obs_sel, 3'b010);
    step(1'b0, 1'b1, 2'b10, 32'h8BFF_FFFC, 1'b0);
    chk("dec_r2_sel", obs_sel, 3'b100);
    step(1'b0, 1'b1, 2'b10, 32'h8C00_0000, 1'b0);
    chk("dec_top_sel", obs_sel, 3'b000);
    chk("dec_top_valid", obs_valid, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h0, 1'b0);

    // Pipeline latency and hold
    step(1'b0, 1'b1, 2'b00, 32'h1000_000A, 1'b1);
    step(1'b0, 1'b1, 2'b00, 32'h1000_000B, 1'b0);
    chk("pipe_s1_a", haddr_p[ADDR_W +: ADDR_W], 32'h1000_000A);
    chk("pipe_s0_b", haddr_p[0 +: ADDR_W], 32'h1000_000B);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 2'b10, $urandom, 1'b1);
    chk("hold_s1_a", haddr_p[ADDR_W +: ADDR_W], 32'h1000_000A);
    chk("hold_s0_b", haddr_p[0 +: ADDR_W], 32'h1000_000B);

    // Error response, SEQ ignored during ST_ERR1
    step(1'b0, 1'b1, 2'b10, 32'h9000_0000, 1'b0);
    chk("err1_hresp", bus.hresp, 1'b1);
    chk("err1_hreadyout", bus.hreadyout, 1'b0);
    step(1'b0, 1'b1, 2'b11, 32'h8000_0100, 1'b0);
    chk("err1_seq_valid", obs_valid, 1'b0);
    chk("err2_hresp", bus.hresp, 1'b1);
    chk("err2_hreadyout", bus.hreadyout, 1'b1);
    step(1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
    chk("err_done_hresp", bus.hresp, 1'b0);

    // BUSY/IDLE filtering
    step(1'b0, 1'b1, 2'b10, 32'h8000_0000, 1'b0);
    step(1'b0, 1'b1, 2'b01, 32'h8400_0000, 1'b0);
    chk("busy_valid", obs_valid, 1'b0);
    chk("busy_selx_q", selx_q, 3'b001);
    step(1'b0, 1'b1, 2'b00, 32'h8800_0000, 1'b0);
    chk("idle_selx_q", selx_q, 3'b001);
    step(1'b0, 1'b1, 2'b01, 32'h9000_0000, 1'b0);
    chk("busy_oor_hresp", bus.hresp, 1'b0);

    // Reset during an error sequence
    step(1'b0, 1'b1, 2'b10, 32'h9000_0000, 1'b0);
    step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    chk("rst_mid_hresp", bus.hresp, 1'b0);
    chk("rst_mid_hreadyout", bus.hreadyout, 1'b1);

`ifdef AHB_SLV_STATS_EN
    step(1'b1, 1'b1, 2'b00, 32'h0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 2'b10, 32'h8000_0040, 1'b1);
    step(1'b0, 1'b1, 2'b10, 32'h9000_0000, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
    step(1'b0, 1'b1, 2'b00, 32'h0, 1'b0);
    chk("stats_xfer3", xfer_cnt, 16'd3);
    chk("stats_err1", err_cnt, 16'd1);
    for (int i = 0; i < 65532; i++) step(1'b0, 1'b1, 2'b11, 32'h8400_0000, 1'b0);
    chk("stats_xfer_max", xfer_cnt, 16'hFFFF);
    step(1'b0, 1'b1, 2'b10, 32'h8400_0000, 1'b0);
    chk("stats_xfer_sat", xfer_cnt, 16'hFFFF);
`endif

    // Randomized traffic
    for (int i = 0; i < 800; i++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
           2'($urandom_range(0, 3)), rand_addr(), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule

// File: doc/ahb_slave_if_param.md
Name: ahb_slave_if_param

Overview:
Parametrised AHB-Lite slave front-end for the AHB-to-APB bridge. It decodes incoming transfers across NUM_SEL equal-sized APB regions. Address, data and write pipelines have configurable depth and advance only on hreadyin. Out-of-range NONSEQ/SEQ transfers get a two-cycle AHB ERROR response from a local FSM. It feeds the bridge APB controller FSM and returns prdata as hrdata.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
NUM_SEL, 3, number of APB select regions (1..8)
BASE_ADDR, 32'h8000_0000, start address of region 0
REGION_SIZE, 32'h0400_0000, byte size of each region (power of two)
PIPE_DEPTH, 2, pipeline stages on address/data/write (1..4)

Ports:
hclk  in  1  bridge clock, all logic on rising edge
hreset  in  1  synchronous, active-high reset
hwrite  in  1  AHB write/read indicator
hreadyin  in  1  AHB bus ready; pipeline enable
htrans  in  2  AHB transfer type (00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ)
haddr  in  ADDR_W  AHB address
hwdata  in  DATA_W  AHB write data
prdata  in  DATA_W  APB read data from bridge
haddr_p  out  ADDR_W*PIPE_DEPTH  address pipeline; stage k at bits [k*ADDR_W +: ADDR_W]; stage 0 newest
hwdata_p  out  DATA_W*PIPE_DEPTH  write-data pipeline, same packing
hwrite_p  out  PIPE_DEPTH  hwrite pipeline; bit k is stage k
valid  out  1  accepted in-range transfer this cycle (combinational)
temp_selx  out  NUM_SEL  one-hot region decode of haddr (combinational)
selx_q  out  NUM_SEL  temp_selx registered on each valid cycle
hrdata  out  DATA_W  equals prdata (combinational)
hresp  out  1  0 OKAY, 1 ERROR
hreadyout  out  1  slave ready to the AHB interconnect

Behaviour:
- Reset values when hreset=1 at a clock edge:
  - All pipeline stages, selx_q and hresp are 0.
  - hreadyout is 1.
  - FSM enters ST_IDLE.
- in_range = (haddr >= BASE_ADDR) && (haddr < BASE_ADDR + NUM_SEL*REGION_SIZE).
- Compute the comparison at ADDR_W+4 bits so the upper bound cannot overflow.
- temp_selx[i] = 1 when haddr is in [BASE_ADDR + i*REGION_SIZE, BASE_ADDR + (i+1)*REGION_SIZE); otherwise all zeros. It is never more than one-hot.
- active = hreadyin && htrans[1] (NONSEQ or SEQ). BUSY and IDLE are never active.
- valid = active && in_range && (state==ST_IDLE).
- Pipeline:
  - When hreadyin=1, stage 0 loads haddr/hwdata/hwrite and stage k loads stage k-1.
  - When hreadyin=0, every stage holds its value.
  - Latency from input to the last stage is PIPE_DEPTH enabled cycles.
- selx_q loads temp_selx when valid=1, otherwise it holds.
- FSM:
  - ST_IDLE: hresp=0, hreadyout=1. If active && !in_range, go to ST_ERR1.
  - ST_ERR1: hresp=1, hreadyout=0. Always go to ST_ERR2, whatever htrans is (a master cancel to IDLE does not shorten the response).
  - ST_ERR2: hresp=1, hreadyout=1. Always go to ST_IDLE.
- Outputs are registered from the state, so the ERROR response starts one cycle after the offending address phase.
- A transfer presented during ST_ERR1 or ST_ERR2 is not decoded: valid=0, no state change.
- An out-of-range transfer in the cycle after ST_ERR2 (back in ST_IDLE) starts a new error sequence.
- hreset asserted mid-error: the next edge forces ST_IDLE, hresp=0, hreadyout=1.
- hrdata = prdata at all times, with no register.

Optional Feature:
- Macro: AHB_SLV_STATS_EN.
- Defined: adds output ports xfer_cnt[15:0] and err_cnt[15:0].
  - xfer_cnt increments on each valid=1 cycle.
  - err_cnt increments on each ST_IDLE->ST_ERR1 transition.
  - Both saturate at 16'hFFFF (no wrap) and reset to 0.
- Undefined: neither the ports nor the counters exist; all other behaviour is identical.

Test Plan:
- Reset: hreset=1 for 2 cycles -> all pipeline stages 0, hresp=0, hreadyout=1, selx_q=0.
- Region decode, defaults, htrans=10, hreadyin=1:
  - haddr=8000_0010 -> temp_selx=001, valid=1.
  - haddr=8400_0000 -> 010.
  - haddr=8BFF_FFFC -> 100.
  - haddr=8C00_0000 -> 000, valid=0.
- Pipeline latency, PIPE_DEPTH=2: haddr=A, then B, with hreadyin=1 -> stage1=A two edges after A is presented. Drop hreadyin for 3 cycles -> stages hold A/B unchanged.
- Error response: NONSEQ to 9000_0000 -> next cycle hresp=1, hreadyout=0; following cycle hresp=1, hreadyout=1; then hresp=0. A SEQ in-range transfer during ST_ERR1 gives valid=0.
- BUSY/IDLE filter: htrans=01 or 00 with in-range haddr -> valid=0, selx_q unchanged. htrans=01 to 9000_0000 -> no error.
- With AHB_SLV_STATS_EN: 3 valid transfers plus 1 error -> xfer_cnt=3, err_cnt=1. Preload via 65535 transfers, then one more -> xfer_cnt stays FFFF.
